ecsu_filtered: RTL and testbench
================================

Name: ecsu_filtered

Overview:
- Parametrised next-generation environmental control and safety unit.
- Classifies weather inputs into four escalating states: CLEAR, CAUTION, SEVERE, EMERGENCY.
- Adds configurable thresholds and widths, persistence filtering (debounce) on every transition, explicit acknowledge to leave EMERGENCY, and dwell/transition status.
- Sits between the sensor front-end and the flight-deck alert logic.

Parameters:
WIND_W, 6, wind input width (unsigned)
TEMP_W, 8, temperature input width (signed two's complement)
WIND_CAUTION, 10, wind above this (with reduced visibility) is CAUTION; at or below it is calm
WIND_SEVERE, 15, wind above this is SEVERE; must be >= WIND_CAUTION
WIND_EMERG, 20, wind above this is EMERGENCY; must be >= WIND_SEVERE
TEMP_SEVERE, 35, |temperature| above this is SEVERE
TEMP_EMERG, 40, |temperature| above this is EMERGENCY; must be >= TEMP_SEVERE
PERSIST_CYC, 4, consecutive cycles an escalation condition must hold (>= 1)
RECOVER_CYC, 8, consecutive cycles a de-escalation condition must hold (>= 1)
DWELL_W, 16, width of the dwell counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
thunderstorm  input  1  thunderstorm detected
wind  input  WIND_W  wind speed, unsigned
visibility  input  2  00 good, 01 reduced, 10 poor, 11 zero
temperature  input  TEMP_W  signed temperature
ack  input  1  crew acknowledge pulse
ECSU_state  output  2  current state: 00 CLEAR, 01 CAUTION, 10 SEVERE, 11 EMERGENCY
severe_weather  output  1  high in SEVERE or EMERGENCY
emergency_landing_alert  output  1  high in EMERGENCY only
state_change  output  1  one-cycle pulse in the cycle after any state change
dwell_count  output  DWELL_W  cycles spent in current state, saturating

Behaviour:
- Reset (RST=0, async): ECSU_state=CLEAR, severe_weather=0, emergency_landing_alert=0, state_change=0, dwell_count=0, persistence counter=0, registered candidate=CLEAR. The same values apply on reset mid-filter or mid-EMERGENCY.
- Temperature comparisons are signed. t_in(T) means -T <= temperature <= T.
- Condition terms, evaluated combinationally:
  - sev: wind>WIND_SEVERE | visibility==11 | !t_in(TEMP_SEVERE) | thunderstorm
  - emg: wind>WIND_EMERG | !t_in(TEMP_EMERG); by the parameter constraints, emg implies sev
  - cau: !sev & wind>WIND_CAUTION & visibility!=00
  - calm: !sev & wind<=WIND_CAUTION & visibility==00
  - relax: !sev & wind<=WIND_CAUTION & visibility<=01
- Candidate target per state, in priority order:
  - CLEAR: sev->SEVERE, else cau->CAUTION, else CLEAR
  - CAUTION: sev->SEVERE, else calm->CLEAR, else CAUTION
  - SEVERE: emg->EMERGENCY, else relax->CAUTION, else SEVERE
  - EMERGENCY: ack & !sev->CAUTION (bypasses persistence, takes effect next edge); otherwise EMERGENCY. ack is ignored in other states.
- Persistence filter:
  - N = PERSIST_CYC if the candidate is higher than the current state, RECOVER_CYC if lower.
  - If candidate==state, the counter clears to 0.
  - Otherwise run = (candidate==registered candidate) ? counter+1 : 1.
  - If run>=N, the state takes the candidate at this edge and the counter clears to 0. Else counter<=run.
  - Any interruption or change of candidate restarts the count. PERSIST_CYC=1 gives single-edge transitions.
- Output timing:
  - severe_weather and emergency_landing_alert are decoded from the state register: zero extra latency and glitch-free.
  - state_change is registered: high for exactly one cycle after each transition.
- dwell_count:
  - Goes to 0 on the transition edge, then increments each cycle.
  - Saturates at 2^DWELL_W-1 with no wrap.
- Counter width: clog2(max(PERSIST_CYC,RECOVER_CYC)+1).
- No latches. The next-state block assigns every signal on every path; unreachable encodings go to CLEAR.

Decomposition:
- Package ecsu_pkg holds:
  - state codes ST_CLEAR/ST_CAUTION/ST_SEVERE/ST_EMERG
  - visibility codes VIS_GOOD/VIS_REDUCED/VIS_POOR/VIS_ZERO
  - a severity-compare function
- One sub-module, ecsu_persist_filter, holds the candidate register, run counter and fire output. It is parametrised by counter width and takes N as an input.

Test Plan:
- Reset mid-filter: wind=12, vis=01 for 2 cycles with PERSIST=4, then RST low -> all outputs 0, state CLEAR; after release a fresh 4-cycle count is needed.
- Escalation debounce: wind=16 for 3 cycles, one cycle of wind=5, then wind=16 for 4 cycles -> SEVERE only after the final 4th cycle; state_change pulses once; severe_weather=1.
- Temperature sign and boundaries: temp=-35 stays CLEAR; temp=-36 for 4 cycles -> SEVERE; then temp=+41 for 4 cycles -> EMERGENCY, alert=1.
- EMERGENCY hold: wind=0, vis=00 for 100 cycles without ack -> stays EMERGENCY; ack while thunderstorm=1 ignored; ack with sev=0 -> CAUTION next edge, alert=0.
- Recovery: in CAUTION, calm inputs for 7 cycles then 1 noisy cycle, then 8 calm cycles -> CLEAR only after 8 uninterrupted; dwell_count resets to 0 at the change.
- Dwell saturation with DWELL_W=4: hold CLEAR for 20 cycles -> dwell_count sticks at 15.

Source files
------------

// File: rtl/ecsu_pkg.sv
// Shared state/visibility encodings and the severity ordering helper
// for the environmental control and safety unit.
package ecsu_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'b00,
        ST_CAUTION = 2'b01,
        ST_SEVERE  = 2'b10,
        ST_EMERG   = 2'b11
    } ecsu_state_e;

    localparam logic [1:0] VIS_GOOD    = 2'b00;
    localparam logic [1:0] VIS_REDUCED = 2'b01;
    localparam logic [1:0] VIS_POOR    = 2'b10;
    localparam logic [1:0] VIS_ZERO    = 2'b11;

    // Encodings are ordered by severity, so a numeric compare ranks them.
    function automatic logic sev_higher(input ecsu_state_e a, input ecsu_state_e b);
        return (a > b);
    endfunction

endpackage

// File: rtl/ecsu_persist_filter.sv
// Persistence (debounce) filter: a candidate must repeat for N consecutive
// edges before it fires; a bypass request fires immediately.
module ecsu_persist_filter
    import ecsu_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  ecsu_state_e      i_cand,
    input  ecsu_state_e      i_state,
    input  logic [CNT_W-1:0] i_n,
    input  logic             i_bypass,
    output logic             o_fire
);

    ecsu_state_e      r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_run;
    logic             w_same;

    // Run length of the current candidate and the fire decision.
    always_comb begin
        w_same = (i_cand == i_state);
        if (i_cand == r_cand) begin
            w_run = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
        end else begin
            w_run = {{CNT_W{1'b0}}, 1'b1};
        end
        o_fire = !w_same && (i_bypass || (w_run >= {1'b0, i_n}));
    end

    // Candidate history and run counter; cleared on settle or on firing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cand <= ST_CLEAR;
            r_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_cand <= i_cand;
            if (w_same || o_fire) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= w_run[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ecsu_filtered.sv
// Environmental control and safety unit: classifies weather into four
// escalating states with debounced transitions and acknowledged exit from EMERGENCY.
module ecsu_filtered
    import ecsu_pkg::*;
#(
    parameter int WIND_W       = 6,
    parameter int TEMP_W       = 8,
    parameter int WIND_CAUTION = 10,
    parameter int WIND_SEVERE  = 15,
    parameter int WIND_EMERG   = 20,
    parameter int TEMP_SEVERE  = 35,
    parameter int TEMP_EMERG   = 40,
    parameter int PERSIST_CYC  = 4,
    parameter int RECOVER_CYC  = 8,
    parameter int DWELL_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               thunderstorm,
    input  logic [WIND_W-1:0]  wind,
    input  logic [1:0]         visibility,
    input  logic [TEMP_W-1:0]  temperature,
    input  logic               ack,
    output logic [1:0]         ECSU_state,
    output logic               severe_weather,
    output logic               emergency_landing_alert,
    output logic               state_change,
    output logic [DWELL_W-1:0] dwell_count
);

    localparam int CNT_MAX = (PERSIST_CYC > RECOVER_CYC) ? PERSIST_CYC : RECOVER_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TW1     = TEMP_W + 1;

    localparam logic [CNT_W-1:0]   L_PERSIST   = CNT_W'(PERSIST_CYC);
    localparam logic [CNT_W-1:0]   L_RECOVER   = CNT_W'(RECOVER_CYC);
    localparam logic [WIND_W-1:0]  L_WIND_CAU  = WIND_W'(WIND_CAUTION);
    localparam logic [WIND_W-1:0]  L_WIND_SEV  = WIND_W'(WIND_SEVERE);
    localparam logic [WIND_W-1:0]  L_WIND_EMG  = WIND_W'(WIND_EMERG);
    localparam logic signed [TEMP_W:0] L_TEMP_SEV = TW1'(TEMP_SEVERE);
    localparam logic signed [TEMP_W:0] L_TEMP_EMG = TW1'(TEMP_EMERG);
    localparam logic [DWELL_W-1:0] L_DWELL_MAX = {DWELL_W{1'b1}};

    ecsu_state_e        r_state;
    logic               r_state_change;
    logic [DWELL_W-1:0] r_dwell;

    ecsu_state_e        w_cand;
    ecsu_state_e        w_next;
    logic [CNT_W-1:0]   w_n;
    logic               w_bypass;
    logic               w_fire;
    logic signed [TEMP_W:0] w_temp;
    logic               w_sev;
    logic               w_emg;
    logic               w_cau;
    logic               w_calm;
    logic               w_relax;
    logic               w_wind_low;

    // One extra bit keeps -T representable for the signed band checks.
    assign w_temp     = {temperature[TEMP_W-1], temperature};
    assign w_wind_low = (wind <= L_WIND_CAU);
    assign w_sev   = (wind > L_WIND_SEV) || (visibility == VIS_ZERO) || thunderstorm
                   || (w_temp > L_TEMP_SEV) || (w_temp < -L_TEMP_SEV);
    assign w_emg   = (wind > L_WIND_EMG) || (w_temp > L_TEMP_EMG) || (w_temp < -L_TEMP_EMG);
    assign w_cau   = !w_sev && !w_wind_low && (visibility != VIS_GOOD);
    assign w_calm  = !w_sev && w_wind_low && (visibility == VIS_GOOD);
    assign w_relax = !w_sev && w_wind_low && (visibility <= VIS_REDUCED);

    // Candidate target per state, filter threshold and acknowledge bypass.
    always_comb begin
        w_cand   = ST_CLEAR;
        w_bypass = 1'b0;
        w_n      = L_RECOVER;
        case (r_state)
            ST_CLEAR: begin
                if (w_sev)      w_cand = ST_SEVERE;
                else if (w_cau) w_cand = ST_CAUTION;
                else            w_cand = ST_CLEAR;
            end
            ST_CAUTION: begin
                if (w_sev)       w_cand = ST_SEVERE;
                else if (w_calm) w_cand = ST_CLEAR;
                else             w_cand = ST_CAUTION;
            end
            ST_SEVERE: begin
                if (w_emg)        w_cand = ST_EMERG;
                else if (w_relax) w_cand = ST_CAUTION;
                else              w_cand = ST_SEVERE;
            end
            ST_EMERG: begin
                if (ack && !w_sev) begin
                    w_cand   = ST_CAUTION;
                    w_bypass = 1'b1;
                end else begin
                    w_cand   = ST_EMERG;
                end
            end
            default: w_cand = ST_CLEAR;
        endcase
        if (sev_higher(w_cand, r_state)) w_n = L_PERSIST;
        else                             w_n = L_RECOVER;
    end

    ecsu_persist_filter #(
        .CNT_W(CNT_W)
    ) u_filter (
        .CLK      (CLK),
        .RST      (RST),
        .i_cand   (w_cand),
        .i_state  (r_state),
        .i_n      (w_n),
        .i_bypass (w_bypass),
        .o_fire   (w_fire)
    );

    assign w_next = w_fire ? w_cand : r_state;

    // State, transition pulse and saturating dwell counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state        <= ST_CLEAR;
            r_state_change <= 1'b0;
            r_dwell        <= {DWELL_W{1'b0}};
        end else begin
            r_state        <= w_next;
            r_state_change <= (w_next != r_state);
            if (w_next != r_state) begin
                r_dwell <= {DWELL_W{1'b0}};
            end else if (r_dwell != L_DWELL_MAX) begin
                r_dwell <= r_dwell + {{(DWELL_W-1){1'b0}}, 1'b1};
            end else begin
                r_dwell <= r_dwell;
            end
        end
    end

    assign ECSU_state              = r_state;
    assign severe_weather          = r_state[1];
    assign emergency_landing_alert = (r_state == ST_EMERG);
    assign state_change            = r_state_change;
    assign dwell_count             = r_dwell;

endmodule

// File: tb/tb_ecsu_filtered.sv
// Directed self-checking bench for ecsu_filtered (DWELL_W=4 to reach saturation quickly).
module tb_ecsu_filtered;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        thunderstorm = 1'b0;
    logic [5:0]  wind = 6'd0;
    logic [1:0]  visibility = 2'b00;
    logic signed [7:0] temperature = 8'sd0;
    logic        ack = 1'b0;
    logic [1:0]  ECSU_state;
    logic        severe_weather;
    logic        emergency_landing_alert;
    logic        state_change;
    logic [3:0]  dwell_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ecsu_filtered #(.DWELL_W(4)) dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .thunderstorm            (thunderstorm),
        .wind                    (wind),
        .visibility              (visibility),
        .temperature             (temperature),
        .ack                     (ack),
        .ECSU_state              (ECSU_state),
        .severe_weather          (severe_weather),
        .emergency_landing_alert (emergency_landing_alert),
        .state_change            (state_change),
        .dwell_count             (dwell_count)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic calm_inputs();
        thunderstorm = 1'b0; wind = 6'd0; visibility = 2'b00; temperature = 8'sd0; ack = 1'b0;
    endtask

    task automatic do_reset();
        calm_inputs();
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #3;
        n_tests++; if (ECSU_state !== 2'b00) begin $display("FAIL rst_state act=%0d exp=0", ECSU_state); n_fail++; end
        n_tests++; if ({severe_weather, emergency_landing_alert, state_change} !== 3'b000) begin
            $display("FAIL rst_flags act=%b exp=000", {severe_weather, emergency_landing_alert, state_change}); n_fail++; end
        n_tests++; if (dwell_count !== 4'd0) begin $display("FAIL rst_dwell act=%0d exp=0", dwell_count); n_fail++; end
        tick(1);
        RST = 1'b1;
    endtask

    task automatic test_reset_mid_filter();
        do_reset();
        wind = 6'd12; visibility = 2'b01;
        tick(2);
        RST = 1'b0;
        #1;
        n_tests++; if ({ECSU_state, state_change, dwell_count} !== 7'd0) begin
            $display("FAIL midrst_outputs act=%b exp=0", {ECSU_state, state_change, dwell_count}); n_fail++; end
        tick(1);
        RST = 1'b1;
        tick(3);
        n_tests++; if (ECSU_state !== 2'b00) begin $display("FAIL midrst_fresh3 act=%0d exp=0", ECSU_state); n_fail++; end
        tick(1);
        n_tests++; if (ECSU_state !== 2'b01) begin $display("FAIL midrst_fresh4 act=%0d exp=1", ECSU_state); n_fail++; end
        n_tests++; if (state_change !== 1'b1) begin $display("FAIL midrst_sc act=%b exp=1", state_change); n_fail++; end
    endtask

    task automatic test_escalation_debounce();
        do_reset();
        wind = 6'd16;
        tick(3);
        n_tests++; if (ECSU_state !== 2'b00) begin $display("FAIL esc_first3 act=%0d exp=0", ECSU_state); n_fail++; end
        wind = 6'd5;
        tick(1);
        wind = 6'd16;
        tick(3);
        n_tests++; if (ECSU_state !== 2'b00 || state_change !== 1'b0) begin
            $display("FAIL esc_restart3 act=%0d/%b exp=0/0", ECSU_state, state_change); n_fail++; end
        tick(1);
        n_tests++; if (ECSU_state !== 2'b10) begin $display("FAIL esc_state act=%0d exp=2", ECSU_state); n_fail++; end
        n_tests++; if ({severe_weather, emergency_landing_alert, state_change} !== 3'b101) begin
            $display("FAIL esc_flags act=%b exp=101", {severe_weather, emergency_landing_alert, state_change}); n_fail++; end
        n_tests++; if (dwell_count !== 4'd0) begin $display("FAIL esc_dwell0 act=%0d exp=0", dwell_count); n_fail++; end
        tick(1);
        n_tests++; if (state_change !== 1'b0 || dwell_count !== 4'd1) begin
            $display("FAIL esc_after act=%b/%0d exp=0/1", state_change, dwell_count); n_fail++; end
    endtask

    task automatic test_temperature();
        do_reset();
        temperature = -8'sd35;
        tick(6);
        n_tests++; if (ECSU_state !== 2'b00) begin $display("FAIL temp_m35 act=%0d exp=0", ECSU_state); n_fail++; end
        temperature = -8'sd36;
        tick(3);
        n_tests++; if (ECSU_state !== 2'b00) begin $display("FAIL temp_m36_3 act=%0d exp=0", ECSU_state); n_fail++; end
        tick(1);
        n_tests++; if (ECSU_state !== 2'b10) begin $display("FAIL temp_m36_4 act=%0d exp=2", ECSU_state); n_fail++; end
        temperature = 8'sd41;
        tick(3);
        n_tests++; if (ECSU_state !== 2'b10) begin $display("FAIL temp_p41_3 act=%0d exp=2", ECSU_state); n_fail++; end
        tick(1);
        n_tests++; if (ECSU_state !== 2'b11 || emergency_landing_alert !== 1'b1 || severe_weather !== 1'b1) begin
            $display("FAIL temp_emerg act=%0d/%b/%b exp=3/1/1", ECSU_state, emergency_landing_alert, severe_weather); n_fail++; end
    endtask

    task automatic test_emergency_hold();
        calm_inputs();
        tick(100);
        n_tests++; if (ECSU_state !== 2'b11) begin $display("FAIL emg_hold act=%0d exp=3", ECSU_state); n_fail++; end
        n_tests++; if (dwell_count !== 4'd15) begin $display("FAIL emg_dwell act=%0d exp=15", dwell_count); n_fail++; end
        thunderstorm = 1'b1; ack = 1'b1;
        tick(1);
        n_tests++; if (ECSU_state !== 2'b11) begin $display("FAIL emg_ack_storm act=%0d exp=3", ECSU_state); n_fail++; end
        thunderstorm = 1'b0; ack = 1'b0;
        tick(1);
        n_tests++; if (ECSU_state !== 2'b11) begin $display("FAIL emg_noack act=%0d exp=3", ECSU_state); n_fail++; end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        n_tests++; if (ECSU_state !== 2'b01) begin $display("FAIL emg_ack act=%0d exp=1", ECSU_state); n_fail++; end
        n_tests++; if ({severe_weather, emergency_landing_alert, state_change} !== 3'b001) begin
            $display("FAIL emg_ack_flags act=%b exp=001", {severe_weather, emergency_landing_alert, state_change}); n_fail++; end
    endtask

    task automatic test_recovery();
        calm_inputs();
        tick(7);
        n_tests++; if (ECSU_state !== 2'b01) begin $display("FAIL rec_calm7 act=%0d exp=1", ECSU_state); n_fail++; end
        wind = 6'd12; visibility = 2'b01;
        tick(1);
        calm_inputs();
        tick(7);
        n_tests++; if (ECSU_state !== 2'b01) begin $display("FAIL rec_restart7 act=%0d exp=1", ECSU_state); n_fail++; end
        tick(1);
        n_tests++; if (ECSU_state !== 2'b00 || state_change !== 1'b1 || dwell_count !== 4'd0) begin
            $display("FAIL rec_clear act=%0d/%b/%0d exp=0/1/0", ECSU_state, state_change, dwell_count); n_fail++; end
        tick(1);
        n_tests++; if (state_change !== 1'b0 || dwell_count !== 4'd1) begin
            $display("FAIL rec_after act=%b/%0d exp=0/1", state_change, dwell_count); n_fail++; end
    endtask

    task automatic test_dwell_saturation();
        do_reset();
        tick(14);
        n_tests++; if (dwell_count !== 4'd14) begin $display("FAIL dwell_14 act=%0d exp=14", dwell_count); n_fail++; end
        tick(1);
        n_tests++; if (dwell_count !== 4'd15) begin $display("FAIL dwell_15 act=%0d exp=15", dwell_count); n_fail++; end
        tick(5);
        n_tests++; if (dwell_count !== 4'd15 || ECSU_state !== 2'b00) begin
            $display("FAIL dwell_sat act=%0d/%0d exp=15/0", dwell_count, ECSU_state); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_reset_mid_filter();
        test_escalation_debounce();
        test_temperature();
        test_emergency_hold();
        test_recovery();
        test_dwell_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
